rs232_frame_decoder: RTL and testbench

Byte-to-frame parser directly downstream of the `quick_rs232` receive path. It pops received bytes through the UART's `rx_read` / `rx_data` handshake and hunts for a start-of-frame byte. It validates length and XOR checksum, stores the payload in an internal buffer, and presents a complete frame to the consumer until acknowledged. Line errors, bad length, bad checksum and inter-byte timeouts abort the frame and raise a one-cycle error pulse.

---
 rtl/rs232_frame_decoder.sv | 148 ++++++++++++++
 tb/tb_rs232_frame_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_frame_decoder.sv
// rs232_frame_decoder: pops UART bytes, validates SOF/LEN/payload/XOR-checksum frames and holds them for a consumer
module rs232_frame_decoder #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned MAX_PAYLOAD   = 16,
    parameter logic [7:0]  SOF_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned RX_BUF_LEN    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_byte_received,
    output logic       rx_read,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       frame_valid,
    output logic [7:0] frame_len,
    input  logic       frame_ack,
    input  logic [7:0] pl_addr,
    output logic [7:0] pl_data,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int unsigned PW            = $clog2(RX_BUF_LEN) + 1;
    localparam int unsigned AW            = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned DEPTH         = 1 << AW;
    localparam logic [31:0] TIMEOUT_TICKS = TIMEOUT_BYTES * 11 * CLK_FREQ / BAUD_RATE;
    localparam logic [1:0]  E_LINE = 2'd0, E_LEN = 2'd1, E_CHK = 2'd2, E_TO = 2'd3;

    typedef enum logic [1:0] {F_IDLE = 2'd0, F_READ = 2'd1, F_WAIT = 2'd2, F_SAMPLE = 2'd3} fetch_t;
    typedef enum logic [2:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHECK, P_DONE} parse_t;

    fetch_t        fst_q, fst_d;
    parse_t        pst_q, pst_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [7:0]    byte_q, len_q, len_d, idx_q, idx_d, chk_q, chk_d, pl_q;
    logic          line_q, ack_q, err_q, err_d, wr_en, byte_v, active;
    logic [1:0]    code_q, code_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [7:0]    mem_q [DEPTH];

    assign rx_read     = fst_q == F_READ;
    assign byte_v      = fst_q == F_SAMPLE;
    assign active      = pst_q inside {P_LEN, P_PAYLOAD, P_CHECK};
    assign frame_valid = pst_q == P_DONE;
    assign frame_len   = len_q;
    assign pl_data     = pl_q;
    assign err         = err_q;
    assign err_code    = code_q;

    // Pending count and fetch sequencing; the sequencer wraps SAMPLE back to IDLE and never fetches while a frame is held
    always_comb begin
        pend_d = (rx_byte_received && !rx_read && pend_q != PW'(RX_BUF_LEN)) ? pend_q + 1'b1 :
                 (rx_read && !rx_byte_received && pend_q != '0) ? pend_q - 1'b1 : pend_q;
        fst_d  = (fst_q == F_IDLE) ? ((pend_q != '0 && pst_q != P_DONE) ? F_READ : F_IDLE) : fetch_t'(fst_q + 2'd1);
    end

    // Parser next state; the timeout fires one count early because the err register adds a cycle
    always_comb begin
        pst_d  = pst_q;
        len_d  = len_q;
        idx_d  = idx_q;
        chk_d  = chk_q;
        cnt_d  = active ? cnt_q + 32'd1 : 32'd0;
        err_d  = 1'b0;
        code_d = code_q;
        wr_en  = 1'b0;
        if (byte_v) begin
            cnt_d = 32'd0;
            if (line_q) begin
                err_d  = 1'b1;
                code_d = E_LINE;
                pst_d  = P_HUNT;
            end else begin
                case (pst_q)
                    P_HUNT: pst_d = (byte_q == SOF_BYTE) ? P_LEN : P_HUNT;
                    P_LEN: begin
                        if (byte_q == 8'd0 || byte_q > 8'(MAX_PAYLOAD)) begin
                            err_d  = 1'b1;
                            code_d = E_LEN;
                            pst_d  = P_HUNT;
                        end else begin
                            len_d = byte_q;
                            chk_d = byte_q;
                            idx_d = 8'd0;
                            pst_d = P_PAYLOAD;
                        end
                    end
                    P_PAYLOAD: begin
                        wr_en = 1'b1;
                        chk_d = chk_q ^ byte_q;
                        idx_d = idx_q + 8'd1;
                        pst_d = (idx_q + 8'd1 == len_q) ? P_CHECK : P_PAYLOAD;
                    end
                    P_CHECK: begin
                        err_d  = byte_q != chk_q;
                        code_d = (byte_q != chk_q) ? E_CHK : code_q;
                        pst_d  = (byte_q == chk_q) ? P_DONE : P_HUNT;
                    end
                    default: ;
                endcase
            end
        end else if (active && cnt_q == TIMEOUT_TICKS - 32'd2) begin
            err_d  = 1'b1;
            code_d = E_TO;
            pst_d  = P_HUNT;
        end
        if (pst_q == P_DONE && frame_ack && !ack_q) pst_d = P_HUNT;
    end

    // State and datapath registers; the sampled byte is captured during WAIT and presented in SAMPLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fst_q  <= F_IDLE;
            pst_q  <= P_HUNT;
            pend_q <= '0;
            byte_q <= 8'd0;
            line_q <= 1'b0;
            len_q  <= 8'd0;
            idx_q  <= 8'd0;
            chk_q  <= 8'd0;
            cnt_q  <= 32'd0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            code_q <= 2'd0;
            pl_q   <= 8'd0;
        end else begin
            fst_q  <= fst_d;
            pst_q  <= pst_d;
            pend_q <= pend_d;
            byte_q <= (fst_q == F_WAIT) ? rx_data : byte_q;
            line_q <= (fst_q == F_WAIT) ? rx_err : line_q;
            len_q  <= len_d;
            idx_q  <= idx_d;
            chk_q  <= chk_d;
            cnt_q  <= cnt_d;
            ack_q  <= frame_ack;
            err_q  <= err_d;
            code_q <= code_d;
            pl_q   <= ({1'b0, pl_addr} < 9'(DEPTH)) ? mem_q[pl_addr[AW-1:0]] : pl_q;
        end
    end

    // Payload buffer, deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q[AW-1:0]] <= byte_q;
    end
endmodule

// File: tb/tb_rs232_frame_decoder.sv
// tb_rs232_frame_decoder: scenario and randomized checks of the frame decoder against a frame-level model
module tb_rs232_frame_decoder;
    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned MAXP     = 16;
    localparam int unsigned TOB      = 4;
    localparam int unsigned RXB      = 16;
    localparam logic [7:0]  SOF      = 8'hA5;
    localparam int          TICKS    = TOB * 11 * CLK_FREQ / BAUD;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_byte_received = 1'b0;
    logic       rx_read;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic       frame_ack = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data;
    logic       err;
    logic [1:0] err_code;

    int checks = 0, errors = 0;
    int cyc = 0, n_err = 0, n_rise = 0, n_read = 0, last_read_cyc = 0, err_cyc = 0, min_gap = 1000;
    logic [1:0] last_code = 2'd0;
    logic fv_q = 1'b0;
    logic [8:0] uq[$];

    rs232_frame_decoder #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .MAX_PAYLOAD(MAXP),
        .SOF_BYTE(SOF), .TIMEOUT_BYTES(TOB), .RX_BUF_LEN(RXB)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte_received(rx_byte_received), .rx_read(rx_read),
        .rx_data(rx_data), .rx_err(rx_err), .frame_valid(frame_valid), .frame_len(frame_len),
        .frame_ack(frame_ack), .pl_addr(pl_addr), .pl_data(pl_data), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // UART model and event monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_read) begin
            if (n_read > 0 && cyc - last_read_cyc < min_gap) min_gap = cyc - last_read_cyc;
            n_read++;
            last_read_cyc = cyc;
            if (uq.size() > 0) {rx_err, rx_data} = uq.pop_front();
        end
        if (err) begin
            n_err++;
            last_code = err_code;
            err_cyc = cyc;
        end
        if (frame_valid && !fv_q) n_rise++;
        fv_q = frame_valid;
    end

    function automatic int model(input bq_t q, output int len, output bq_t pl);
        int i = 0;
        logic [7:0] x;
        pl.delete();
        len = 0;
        while (i < q.size() && q[i] != SOF) i++;
        if (i + 1 >= q.size()) return -1;
        len = int'(q[i+1]);
        if (len == 0 || len > int'(MAXP)) return 1;
        x = q[i+1];
        for (int k = 0; k < len; k++) begin
            pl.push_back(q[i+2+k]);
            x = x ^ q[i+2+k];
        end
        return (q[i+2+len] == x) ? 4 : 2;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        uq.push_back({e, b});
        rx_byte_received = 1'b1;
        @(negedge clk);
        rx_byte_received = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b0);
    endtask

    task automatic wait_done(input int e0, input int v0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (n_err != e0 || n_rise != v0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic read_pl(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        pl_addr = a;
        @(negedge clk);
        d = pl_data;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (rx_read !== 1'b0) begin errors++; $display("FAIL reset_rx_read: got %b expected 0", rx_read); end
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        if (frame_len !== 8'h00) begin errors++; $display("FAIL reset_frame_len: got %02h expected 00", frame_len); end
        if (pl_data !== 8'h00) begin errors++; $display("FAIL reset_pl_data: got %02h expected 00", pl_data); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_read !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rx_read=%b frame_valid=%b expected 0 0", rx_read, frame_valid);
        end
    endtask

    task automatic test_basic();
        bq_t q, exp;
        bit ok;
        logic [7:0] d;
        int e0 = n_err, v0 = n_rise;
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        exp = '{8'h11, 8'h22, 8'h33};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        checks += 3;
        if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", frame_valid); end
        if (frame_len !== 8'd3) begin errors++; $display("FAIL basic_len: got %0d expected 3", frame_len); end
        if (n_err != e0) begin errors++; $display("FAIL basic_no_err: got %0d errors expected 0", n_err - e0); end
        for (int k = 0; k < 3; k++) begin
            read_pl(8'(k), d);
            checks++;
            if (d !== exp[k]) begin errors++; $display("FAIL basic_pl[%0d]: got %02h expected %02h", k, d, exp[k]); end
        end
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk) frame_ack = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_drop: got %b expected 0", frame_valid); end
    endtask

    task automatic test_junk();
        bq_t q, exp;
        bit ok;
        logic [7:0] d;
        int e0 = n_err, v0 = n_rise;
        q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
        exp = '{8'hAA, 8'h55};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        checks += 3;
        if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL junk_valid: got %b expected 1", frame_valid); end
        if (frame_len !== 8'd2) begin errors++; $display("FAIL junk_len: got %0d expected 2", frame_len); end
        if (n_err != e0) begin errors++; $display("FAIL junk_no_err: got %0d errors expected 0", n_err - e0); end
        for (int k = 0; k < 2; k++) begin
            read_pl(8'(k), d);
            checks++;
            if (d !== exp[k]) begin errors++; $display("FAIL junk_pl[%0d]: got %02h expected %02h", k, d, exp[k]); end
        end
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk) frame_ack = 1'b0;
    endtask

    task automatic test_bad_chk();
        bq_t q;
        bit ok;
        logic [7:0] d;
        int e0 = n_err, v0 = n_rise;
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        repeat (5) @(negedge clk);
        checks += 3;
        if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL chk_err_count: got %0d expected 1", n_err - e0); end
        if (last_code !== 2'd2) begin errors++; $display("FAIL chk_err_code: got %0d expected 2", last_code); end
        if (n_rise != v0) begin errors++; $display("FAIL chk_no_valid: got %0d frames expected 0", n_rise - v0); end
        e0 = n_err;
        q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        read_pl(8'd0, d);
        checks += 3;
        if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL chk_recover_valid: got %b expected 1", frame_valid); end
        if (frame_len !== 8'd1) begin errors++; $display("FAIL chk_recover_len: got %0d expected 1", frame_len); end
        if (d !== 8'h5A) begin errors++; $display("FAIL chk_recover_pl: got %02h expected 5a", d); end
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk) frame_ack = 1'b0;
    endtask

    task automatic test_bad_len();
        bq_t q;
        bit ok;
        int e0 = n_err, v0 = n_rise;
        q = '{8'hA5, 8'h00};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        checks += 2;
        if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL len0_err_count: got %0d expected 1", n_err - e0); end
        if (last_code !== 2'd1) begin errors++; $display("FAIL len0_err_code: got %0d expected 1", last_code); end
        e0 = n_err;
        q = '{8'hA5, 8'h11};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        checks += 2;
        if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL len17_err_count: got %0d expected 1", n_err - e0); end
        if (last_code !== 2'd1) begin errors++; $display("FAIL len17_err_code: got %0d expected 1", last_code); end
        e0 = n_err;
        q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        checks += 2;
        if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL len_resync_valid: got %b expected 1", frame_valid); end
        if (n_err != e0) begin errors++; $display("FAIL len_resync_no_err: got %0d errors expected 0", n_err - e0); end
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk) frame_ack = 1'b0;
    endtask

    task automatic test_timeout();
        bq_t q;
        bit ok;
        int e0 = n_err, v0 = n_rise;
        q = '{8'hA5, 8'h02, 8'h11};
        send_seq(q);
        wait_done(e0, v0, TICKS + 100, ok);
        repeat (3) @(negedge clk);
        checks += 3;
        if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", n_err - e0); end
        if (last_code !== 2'd3) begin errors++; $display("FAIL timeout_code: got %0d expected 3", last_code); end
        if (err_cyc - (last_read_cyc + 2) != TICKS) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles expected %0d", err_cyc - (last_read_cyc + 2), TICKS);
        end
        e0 = n_err;
        q = '{8'hA5, 8'h02};
        send_seq(q);
        send_byte(8'h33, 1'b1);
        wait_done(e0, v0, 200, ok);
        checks += 3;
        if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL line_count: got %0d expected 1", n_err - e0); end
        if (last_code !== 2'd0) begin errors++; $display("FAIL line_code: got %0d expected 0", last_code); end
        if (n_rise != v0) begin errors++; $display("FAIL line_no_valid: got %0d frames expected 0", n_rise - v0); end
    endtask

    task automatic test_hold();
        bq_t q;
        bit ok;
        int e0 = n_err, v0 = n_rise, r0;
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(q);
        wait_done(e0, v0, 200, ok);
        r0 = n_read;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (20) @(negedge clk);
        checks += 2;
        if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", frame_valid); end
        if (n_read != r0) begin errors++; $display("FAIL hold_no_read: got %0d reads expected 0", n_read - r0); end
        min_gap = 1000;
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_ack_drop: got %b expected 0", frame_valid); end
        repeat (3) @(negedge clk);
        frame_ack = 1'b0;
        repeat (30) @(negedge clk);
        checks += 4;
        if (n_read - r0 != 3) begin errors++; $display("FAIL hold_reads: got %0d expected 3", n_read - r0); end
        if (min_gap < 4) begin errors++; $display("FAIL hold_read_gap: got %0d expected >=4", min_gap); end
        if (n_rise - v0 != 1) begin errors++; $display("FAIL hold_single_frame: got %0d expected 1", n_rise - v0); end
        if (n_err != e0) begin errors++; $display("FAIL hold_no_err: got %0d errors expected 0", n_err - e0); end
    endtask

    task automatic test_reset_mid();
        bq_t q;
        int e0 = n_err, v0 = n_rise;
        q = '{8'hA5, 8'h04, 8'h11, 8'h22};
        send_seq(q);
        rst = 1'b0;
        uq.delete();
        @(negedge clk);
        checks++;
        if (rx_read !== 1'b0 || frame_valid !== 1'b0 || frame_len !== 8'h00 || pl_data !== 8'h00 || err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rd=%b fv=%b len=%02h pl=%02h err=%b code=%0d expected all 0",
                     rx_read, frame_valid, frame_len, pl_data, err, err_code);
        end
        rst = 1'b1;
        q = '{8'h33, 8'h44, 8'h40};
        send_seq(q);
        repeat (40) @(negedge clk);
        checks += 2;
        if (n_rise != v0 || frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_valid: got %0d frames expected 0", n_rise - v0); end
        if (n_err != e0) begin errors++; $display("FAIL midreset_no_err: got %0d errors expected 0", n_err - e0); end
    endtask

    task automatic test_random();
        bq_t q, pl;
        bit ok;
        logic [7:0] b, x, d;
        int kind, len, exp, elen, e0, v0;
        for (int it = 0; it < 20; it++) begin
            q.delete();
            for (int j = int'($urandom_range(0, 3)); j > 0; j--) begin
                b = 8'($urandom_range(0, 255));
                q.push_back(b == SOF ? 8'h00 : b);
            end
            kind = int'($urandom_range(0, 3));
            q.push_back(SOF);
            if (kind == 0) begin
                q.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)));
            end else begin
                len = int'($urandom_range(1, MAXP));
                x = 8'(len);
                q.push_back(8'(len));
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    x = x ^ b;
                    q.push_back(b);
                end
                q.push_back(kind == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
            end
            exp = model(q, elen, pl);
            e0 = n_err;
            v0 = n_rise;
            send_seq(q);
            wait_done(e0, v0, 300, ok);
            repeat (2) @(negedge clk);
            if (exp == 4) begin
                checks += 3;
                if (!ok || frame_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_valid: got %b expected 1", it, frame_valid); end
                if (frame_len !== 8'(elen)) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", it, frame_len, elen); end
                if (n_err != e0) begin errors++; $display("FAIL rand%0d_no_err: got %0d errors expected 0", it, n_err - e0); end
                for (int k = 0; k < elen; k++) begin
                    read_pl(8'(k), d);
                    checks++;
                    if (d !== pl[k]) begin errors++; $display("FAIL rand%0d_pl[%0d]: got %02h expected %02h", it, k, d, pl[k]); end
                end
                @(negedge clk) frame_ack = 1'b1;
                @(negedge clk) frame_ack = 1'b0;
            end else begin
                checks += 3;
                if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL rand%0d_err_count: got %0d expected 1", it, n_err - e0); end
                if (last_code !== 2'(exp)) begin errors++; $display("FAIL rand%0d_err_code: got %0d expected %0d", it, last_code, exp); end
                if (n_rise != v0) begin errors++; $display("FAIL rand%0d_no_valid: got %0d frames expected 0", it, n_rise - v0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_junk();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
